// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if: valid/ready word stream leaving the FIFO reader.
interface fifo_stream_reader_if #(
   parameter int DATA_WIDTH = 64
);
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;
   modport master (output m_valid, output m_data, input m_ready);
   modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: prefetches the synchronous FIFO into a small local buffer and serves it as a valid/ready stream.
module fifo_stream_reader #(
   parameter int DATA_WIDTH     = 64,
   parameter int BUF_ADDR_WIDTH = 2,
   parameter int BUF_DEPTH      = 1 << BUF_ADDR_WIDTH,
   parameter int COUNT_WIDTH    = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    fifo_empty,
   output logic                    fifo_pop,
   input  logic [DATA_WIDTH-1:0]   fifo_data_out,
   fifo_stream_reader_if.master    m,
   output logic [BUF_ADDR_WIDTH:0] occupancy,
   output logic [COUNT_WIDTH-1:0]  words_delivered
);
   localparam logic [BUF_ADDR_WIDTH+1:0] depth_w = (BUF_ADDR_WIDTH+2)'(BUF_DEPTH);
   localparam logic [BUF_ADDR_WIDTH:0]   full_w  = (BUF_ADDR_WIDTH+1)'(BUF_DEPTH);
   logic [DATA_WIDTH-1:0]     buf_mem [BUF_DEPTH];
   logic [BUF_ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
   logic [BUF_ADDR_WIDTH:0]   occ;
   logic [BUF_ADDR_WIDTH+1:0] pending;
   logic                      inflight, cap, hs;
   // Pops are budgeted against held plus in-flight words, so m_ready never reaches fifo_pop.
   always_comb begin
      pending  = {1'b0, occ} + {{(BUF_ADDR_WIDTH+1){1'b0}}, inflight};
      fifo_pop = !reset && !flush && !fifo_empty && (pending < depth_w);
      cap      = inflight && !flush && !reset;
      hs       = m.m_valid && m.m_ready && !flush && !reset;
   end
   assign m.m_valid = (occ != '0);
   assign m.m_data  = buf_mem[rd_ptr];
   assign occupancy = occ;
   always_ff @(posedge clk) begin
      if (cap) buf_mem[wr_ptr] <= fifo_data_out;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         occ             <= '0;
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         inflight        <= 1'b0;
         words_delivered <= '0;
      end else begin
         inflight <= fifo_pop;
         if (flush) begin
            occ    <= '0;
            rd_ptr <= wr_ptr;
         end else begin
            if (cap) wr_ptr <= wr_ptr + 1'b1;
            if (hs) begin
               rd_ptr          <= rd_ptr + 1'b1;
               words_delivered <= words_delivered + 1'b1;
            end
            occ <= occ + (BUF_ADDR_WIDTH+1)'(cap) - (BUF_ADDR_WIDTH+1)'(hs);
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!reset) assert (!(cap && occ == full_w));
   end
endmodule
